// File: rtl/adder_scheduler.sv
// adder_scheduler: two requesters share one nibble-serial 4-bit ripple adder.
// A round-robin arbiter captures one operand pair in IDLE. RUN then adds one
// nibble per cycle, from the least significant nibble upward. DONE holds the
// result until the consumer takes it.
module adder_scheduler #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [4*NIBBLES-1:0] a0,
  input  logic [4*NIBBLES-1:0] b0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [4*NIBBLES-1:0] a1,
  input  logic [4*NIBBLES-1:0] b1,
  output logic                 ack1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [4*NIBBLES:0]   res_sum,
  output logic                 busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W:0]       sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             grant;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib;
  logic [W:0]       nib_mask, nib_val;

  // The only adder in the block: 4 bits plus carry-in, giving 5 bits.
  function automatic logic [4:0] add_nibble(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       cin);
    return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

  // Next-state logic: arbitration, nibble add and the result handshake.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    grant    = 1'b0;
    a_nib    = 4'(a_q >> {cnt_q, 2'b00});
    b_nib    = 4'(b_q >> {cnt_q, 2'b00});
    nib      = add_nibble(a_nib, b_nib, carry_q);
    nib_mask = (W+1)'(4'hF) << {cnt_q, 2'b00};
    nib_val  = (W+1)'(nib[3:0]) << {cnt_q, 2'b00};
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // If both requesters ask, grant the one that was not granted last.
          grant   = (req0 && req1) ? ~last_q : req1;
          a_d     = grant ? a1 : a0;
          b_d     = grant ? b1 : b0;
          id_d    = grant;
          last_d  = grant;
          carry_d = 1'b0;
          cnt_d   = '0;
          ack0_d  = ~grant;
          ack1_d  = grant;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~nib_mask) | nib_val;
        carry_d = nib[4];
        if (cnt_q == LAST_NIB) begin
          sum_d[W] = nib[4];
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // Operand latches; only consumed in RUN, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign res_valid = (state_q == DONE);
  assign res_id    = id_q;
  assign res_sum   = sum_q;
  assign busy      = (state_q != IDLE);

endmodule
